simt_divergence_ctrl: RTL and testbench

- Drives the SIMT stack from the branch-resolution side: pushes stack entries on divergent branches and pops them at reconvergence points.
- Tracks the warp's active thread mask and current reconvergence (sync) PC.
- Issues fetch redirects and stalls the front end during stack transactions.
- Sits between execute-stage branch resolution, the fetch PC, and the `simt_stack` block.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/simt_divergence_ctrl_classify.sv | 34 +++
 rtl/simt_divergence_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_simt_divergence_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the SIMT divergence controller.
//   word_t        : 32-bit PC / address word
//   RECONV_NONE   : sync PC meaning "top level, no pending reconvergence"
//   simt_state_e  : controller FSM states (ERR only with SIMT_STACK_CHECK_EN)
//   simt_entry_t  : packed stack entry {mask, sync, addr}
//   br_class_e    : branch classification result
package cpu_types_pkg;

  localparam int unsigned SIMT_THREADS = 4;

  typedef logic [31:0] word_t;

  localparam word_t RECONV_NONE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_RECONV,
    PUSH_ALT,
    POP
`ifdef SIMT_STACK_CHECK_EN
    , ERR
`endif
  } simt_state_e;

  typedef struct packed {
    logic [SIMT_THREADS-1:0] mask;
    word_t                   sync;
    word_t                   addr;
  } simt_entry_t;

  typedef enum logic [1:0] {
    BR_NOT_TAKEN,
    BR_TAKEN,
    BR_DIVERGENT
  } br_class_e;

endpackage

// File: rtl/simt_divergence_ctrl_classify.sv
// simt_branch_classify: combinational branch outcome classifier.
// Ports:
//   i_active  : current warp active mask
//   i_taken   : per-thread taken outcome (inactive bits ignored)
//   o_t       : active threads that take the branch
//   o_n       : active threads that fall through
//   o_class   : uniform taken / uniform not-taken / divergent
module simt_branch_classify
  import cpu_types_pkg::*;
#(
  parameter int unsigned THREADS = SIMT_THREADS
) (
  input  logic [THREADS-1:0] i_active,
  input  logic [THREADS-1:0] i_taken,
  output logic [THREADS-1:0] o_t,
  output logic [THREADS-1:0] o_n,
  output br_class_e          o_class
);

  logic [THREADS-1:0] w_t;

  always_comb begin
    w_t     = i_active & i_taken;
    o_t     = w_t;
    o_n     = i_active & ~i_taken;
    o_class = BR_NOT_TAKEN;
    if (w_t == i_active) begin
      o_class = BR_TAKEN;
    end else if (w_t != '0) begin
      o_class = BR_DIVERGENT;
    end
  end

endmodule

// File: rtl/simt_divergence_ctrl.sv
// simt_divergence_ctrl: drives the SIMT stack from branch resolution.
// Pushes two entries on a divergent branch, pops at reconvergence, tracks
// the warp active mask and current sync PC, redirects fetch and stalls the
// front end while a stack transaction is in progress.
// Optional feature macro: SIMT_STACK_CHECK_EN (stack error -> sticky ERR).
// Ports:
//   CLK, RST                      : clock, synchronous active-high reset
//   br_valid/br_taken_mask        : resolved branch and per-thread outcome
//   br_target/br_fallthru/br_reconv : taken PC, not-taken PC, post-dominator
//   pc_valid/pc                   : PC presented by fetch
//   push_en/push_mask/push_sync/push_addr : stack push port
//   pop_en                        : stack pop
//   top_mask/top_sync/top_addr    : stack top entry
//   stk_overflow/stk_underflow    : stack error flags
//   active_mask                   : warp execution mask
//   redirect_valid/redirect_pc    : one-cycle fetch redirect
//   stall                         : hold fetch/decode
//   err                           : sticky stack error
module simt_divergence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned THREADS = SIMT_THREADS
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               br_valid,
  input  logic [THREADS-1:0] br_taken_mask,
  input  word_t              br_target,
  input  word_t              br_fallthru,
  input  word_t              br_reconv,
  input  logic               pc_valid,
  input  word_t              pc,
  output logic               push_en,
  output logic [THREADS-1:0] push_mask,
  output word_t              push_sync,
  output word_t              push_addr,
  output logic               pop_en,
  input  logic [THREADS-1:0] top_mask,
  input  word_t              top_sync,
  input  word_t              top_addr,
  input  logic               stk_overflow,
  input  logic               stk_underflow,
  output logic [THREADS-1:0] active_mask,
  output logic               redirect_valid,
  output word_t              redirect_pc,
  output logic               stall,
  output logic               err
);

  simt_state_e        r_state;
  simt_state_e        w_next_state;
  logic [THREADS-1:0] r_active;
  word_t              r_sync;
  logic [THREADS-1:0] r_t;
  logic [THREADS-1:0] r_n;
  word_t              r_target;
  word_t              r_fallthru;
  word_t              r_reconv;
  logic               r_redir_v;
  word_t              r_redir_pc;

  logic [THREADS-1:0] w_t;
  logic [THREADS-1:0] w_n;
  br_class_e          w_class;
  logic               w_hit;
  logic               w_stk_err;
  simt_entry_t        w_push;

  simt_branch_classify #(
    .THREADS(THREADS)
  ) u_classify (
    .i_active(r_active),
    .i_taken (br_taken_mask),
    .o_t     (w_t),
    .o_n     (w_n),
    .o_class (w_class)
  );

`ifdef SIMT_STACK_CHECK_EN
  logic r_err;

  assign w_stk_err = stk_overflow | stk_underflow;
  assign err       = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_stk_err) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_stk;

  assign w_unused_stk = stk_overflow ^ stk_underflow;
  assign w_stk_err    = 1'b0;
  assign err          = 1'b0;
`endif

  // A branch in the same IDLE cycle as a reconvergence hit wins; the hit is
  // seen again on a later IDLE cycle because fetch holds the PC.
  assign w_hit = pc_valid && (pc == r_sync) && !br_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (br_valid && (w_class == BR_DIVERGENT)) begin
          w_next_state = PUSH_RECONV;
        end else if (w_hit) begin
          w_next_state = POP;
        end
      end
      PUSH_RECONV: w_next_state = PUSH_ALT;
      PUSH_ALT:    w_next_state = IDLE;
      POP:         w_next_state = IDLE;
`ifdef SIMT_STACK_CHECK_EN
      ERR:         w_next_state = ERR;
`endif
      default:     w_next_state = IDLE;
    endcase
`ifdef SIMT_STACK_CHECK_EN
    if (w_stk_err) begin
      w_next_state = ERR;
    end
`endif
  end

  // Stack port and stall are decoded from state and latched branch fields.
  always_comb begin
    push_en = 1'b0;
    pop_en  = 1'b0;
    w_push  = '0;
    stall   = (r_state != IDLE);
    case (r_state)
      PUSH_RECONV: begin
        push_en     = 1'b1;
        w_push.mask = r_active;
        w_push.sync = r_sync;
        w_push.addr = r_reconv;
      end
      PUSH_ALT: begin
        push_en     = 1'b1;
        w_push.mask = r_n;
        w_push.sync = r_reconv;
        w_push.addr = r_fallthru;
      end
      POP:     pop_en = 1'b1;
      default: ;
    endcase
  end

  assign push_mask      = w_push.mask;
  assign push_sync      = w_push.sync;
  assign push_addr      = w_push.addr;
  assign active_mask    = r_active;
  assign redirect_valid = r_redir_v;
  assign redirect_pc    = r_redir_pc;

  // The pop redirect target is captured from top_addr on the hit edge: the
  // stack is idle between that edge and the POP cycle, so the value is the
  // same one the stack presents during POP, and the output stays registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_active   <= '1;
      r_sync     <= RECONV_NONE;
      r_t        <= '0;
      r_n        <= '0;
      r_target   <= '0;
      r_fallthru <= '0;
      r_reconv   <= '0;
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      r_state   <= w_next_state;
      r_redir_v <= 1'b0;
      if (!w_stk_err) begin
        case (r_state)
          IDLE: begin
            if (br_valid) begin
              if (w_class == BR_TAKEN) begin
                r_redir_v  <= 1'b1;
                r_redir_pc <= br_target;
              end else if (w_class == BR_DIVERGENT) begin
                r_t        <= w_t;
                r_n        <= w_n;
                r_target   <= br_target;
                r_fallthru <= br_fallthru;
                r_reconv   <= br_reconv;
              end
            end else if (w_hit) begin
              r_redir_v  <= 1'b1;
              r_redir_pc <= top_addr;
            end
          end
          PUSH_RECONV: begin
            r_redir_v  <= 1'b1;
            r_redir_pc <= r_target;
          end
          PUSH_ALT: begin
            r_active <= r_t;
            r_sync   <= r_reconv;
          end
          POP: begin
            r_active <= top_mask;
            r_sync   <= top_sync;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
module tb_simt_divergence_ctrl;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       RST;
  logic       br_valid;
  logic [3:0] br_taken_mask;
  word_t      br_target, br_fallthru, br_reconv;
  logic       pc_valid;
  word_t      pc;
  logic       push_en, pop_en;
  logic [3:0] push_mask;
  word_t      push_sync, push_addr;
  logic [3:0] top_mask;
  word_t      top_sync, top_addr;
  logic       stk_overflow, stk_underflow;
  logic [3:0] active_mask;
  logic       redirect_valid;
  word_t      redirect_pc;
  logic       stall, err;

  simt_divergence_ctrl #(.THREADS(4)) dut (
    .CLK(CLK), .RST(RST), .br_valid(br_valid), .br_taken_mask(br_taken_mask),
    .br_target(br_target), .br_fallthru(br_fallthru), .br_reconv(br_reconv),
    .pc_valid(pc_valid), .pc(pc), .push_en(push_en), .push_mask(push_mask),
    .push_sync(push_sync), .push_addr(push_addr), .pop_en(pop_en),
    .top_mask(top_mask), .top_sync(top_sync), .top_addr(top_addr),
    .stk_overflow(stk_overflow), .stk_underflow(stk_underflow),
    .active_mask(active_mask), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Stack environment: a plain LIFO driven by the DUT's push/pop port.
  simt_entry_t env_stk[$];

  always @(posedge CLK) begin
    if (RST) begin
      env_stk.delete();
    end else begin
      if (pop_en && env_stk.size() > 0) void'(env_stk.pop_back());
      if (push_en) env_stk.push_back({push_mask, push_sync, push_addr});
    end
    if (env_stk.size() > 0) begin
      top_mask <= env_stk[$].mask;
      top_sync <= env_stk[$].sync;
      top_addr <= env_stk[$].addr;
    end else begin
      top_mask <= '0;
      top_sync <= '0;
      top_addr <= '0;
    end
  end

  // Reference model: per-cycle expected outputs scheduled as transactions.
  typedef struct packed {
    bit         stall;
    bit         push;
    bit         pop;
    bit         rv;
    bit         er;
    bit         upd;
    logic [3:0] pm;
    word_t      ps;
    word_t      pa;
    word_t      rpc;
    logic [3:0] um;
    word_t      us;
  } exp_t;

  exp_t        cur, nxt, alt;
  exp_t        m_q[$];
  simt_entry_t m_stk[$];
  simt_entry_t m_e;
  logic [3:0]  m_mask = 4'hF;
  logic [3:0]  m_t, m_n;
  word_t       m_sync = RECONV_NONE;
  bit          m_err = 0;
  bit          m_live = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_q.delete();
      m_stk.delete();
      m_mask = 4'hF;
      m_sync = RECONV_NONE;
      m_err  = 0;
      m_live = 1;
      cur    = '0;
    end else if (m_live) begin
      nxt = '0;
`ifdef SIMT_STACK_CHECK_EN
      if (m_err || stk_overflow || stk_underflow) begin
        m_err = 1;
        m_q.delete();
        nxt.stall = 1;
        nxt.er    = 1;
      end else
`endif
      begin
        if (cur.upd) begin
          m_mask = cur.um;
          m_sync = cur.us;
        end
        if (m_q.size() > 0) begin
          nxt = m_q.pop_front();
        end else if (cur.stall) begin
          nxt = '0;
        end else if (br_valid) begin
          m_t = m_mask & br_taken_mask;
          m_n = m_mask & ~br_taken_mask;
          if (m_t == m_mask) begin
            nxt.rv  = 1;
            nxt.rpc = br_target;
          end else if (m_t != 4'h0) begin
            nxt.stall = 1; nxt.push = 1;
            nxt.pm = m_mask; nxt.ps = m_sync; nxt.pa = br_reconv;
            alt = '0;
            alt.stall = 1; alt.push = 1;
            alt.pm = m_n; alt.ps = br_reconv; alt.pa = br_fallthru;
            alt.rv = 1; alt.rpc = br_target;
            alt.upd = 1; alt.um = m_t; alt.us = br_reconv;
            m_q.push_back(alt);
            m_stk.push_back({m_mask, m_sync, br_reconv});
            m_stk.push_back({m_n, br_reconv, br_fallthru});
          end
        end else if (pc_valid && pc == m_sync && m_stk.size() > 0) begin
          m_e = m_stk.pop_back();
          nxt.stall = 1; nxt.pop = 1;
          nxt.rv = 1; nxt.rpc = m_e.addr;
          nxt.upd = 1; nxt.um = m_e.mask; nxt.us = m_e.sync;
        end
      end
      cur = nxt;
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("stall", {31'b0, stall}, {31'b0, cur.stall});
      chk("push_en", {31'b0, push_en}, {31'b0, cur.push});
      if (cur.push) begin
        chk("push_mask", {28'b0, push_mask}, {28'b0, cur.pm});
        chk("push_sync", push_sync, cur.ps);
        chk("push_addr", push_addr, cur.pa);
      end
      chk("pop_en", {31'b0, pop_en}, {31'b0, cur.pop});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, cur.rv});
      if (cur.rv) chk("redirect_pc", redirect_pc, cur.rpc);
      chk("active_mask", {28'b0, active_mask}, {28'b0, m_mask});
      chk("err", {31'b0, err}, {31'b0, cur.er});
    end
  end

  task automatic branch(input logic [3:0] tk, input word_t tgt, input word_t ft, input word_t rc);
    br_valid = 1; br_taken_mask = tk; br_target = tgt; br_fallthru = ft; br_reconv = rc;
  endtask

  initial begin
    RST = 1; br_valid = 0; br_taken_mask = '0; br_target = '0; br_fallthru = '0;
    br_reconv = '0; pc_valid = 0; pc = '0; stk_overflow = 0; stk_underflow = 0;
    step(); step();
    chk("rst_mask", {28'b0, active_mask}, 32'hF);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_redir", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    chk("rst_push", {31'b0, push_en}, 32'h0);
    chk("rst_push_addr", push_addr, 32'h0);
    chk("rst_pop", {31'b0, pop_en}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    RST = 0;

    // uniform taken
    branch(4'hF, 32'h100, 32'h0, 32'h0);
    step(); br_valid = 0;
    chk("ut_redir", {31'b0, redirect_valid}, 32'h1);
    chk("ut_pc", redirect_pc, 32'h100);
    chk("ut_stall", {31'b0, stall}, 32'h0);
    chk("ut_push", {31'b0, push_en}, 32'h0);
    step();
    chk("ut_redir_off", {31'b0, redirect_valid}, 32'h0);
    chk("ut_mask", {28'b0, active_mask}, 32'hF);

    // divergent
    branch(4'h3, 32'h100, 32'h44, 32'h200);
    step(); br_valid = 0;
    chk("dv1_push", {31'b0, push_en}, 32'h1);
    chk("dv1_mask", {28'b0, push_mask}, 32'hF);
    chk("dv1_sync", push_sync, 32'hFFFF_FFFF);
    chk("dv1_addr", push_addr, 32'h200);
    chk("dv1_stall", {31'b0, stall}, 32'h1);
    chk("dv1_redir", {31'b0, redirect_valid}, 32'h0);
    step();
    chk("dv2_push", {31'b0, push_en}, 32'h1);
    chk("dv2_mask", {28'b0, push_mask}, 32'hC);
    chk("dv2_sync", push_sync, 32'h200);
    chk("dv2_addr", push_addr, 32'h44);
    chk("dv2_redir", {31'b0, redirect_valid}, 32'h1);
    chk("dv2_pc", redirect_pc, 32'h100);
    chk("dv2_stall", {31'b0, stall}, 32'h1);
    step();
    chk("dv3_mask", {28'b0, active_mask}, 32'h3);
    chk("dv3_stall", {31'b0, stall}, 32'h0);

    // reconvergence: two pops
    pc_valid = 1; pc = 32'h200;
    step();
    chk("p1_pop", {31'b0, pop_en}, 32'h1);
    chk("p1_redir", {31'b0, redirect_valid}, 32'h1);
    chk("p1_pc", redirect_pc, 32'h44);
    chk("p1_stall", {31'b0, stall}, 32'h1);
    step();
    chk("p1_mask", {28'b0, active_mask}, 32'hC);
    chk("p1_pop_off", {31'b0, pop_en}, 32'h0);
    step();
    chk("p2_pop", {31'b0, pop_en}, 32'h1);
    chk("p2_pc", redirect_pc, 32'h200);
    step();
    chk("p2_mask", {28'b0, active_mask}, 32'hF);
    step();
    chk("p2_nohit", {31'b0, pop_en}, 32'h0);
    pc_valid = 0;

    // branch and reconvergence hit in the same cycle
    branch(4'h3, 32'h180, 32'h60, 32'h300);
    step(); br_valid = 0;
    step(); step();
    chk("sm_mask", {28'b0, active_mask}, 32'h3);
    branch(4'hC, 32'h500, 32'h504, 32'h600);
    pc_valid = 1; pc = 32'h300;
    step(); br_valid = 0;
    chk("sm_br_first", {31'b0, pop_en}, 32'h0);
    chk("sm_stall", {31'b0, stall}, 32'h0);
    step();
    chk("sm_pop", {31'b0, pop_en}, 32'h1);
    chk("sm_pc", redirect_pc, 32'h60);
    step();
    chk("sm_mask_c", {28'b0, active_mask}, 32'hC);
    step();
    chk("sm_pop2", {31'b0, pop_en}, 32'h1);
    chk("sm_pc2", redirect_pc, 32'h300);
    pc_valid = 0;
    step();
    chk("sm_mask_f", {28'b0, active_mask}, 32'hF);

    // reset during PUSH_ALT
    branch(4'h3, 32'h100, 32'h44, 32'h200);
    step(); br_valid = 0;
    chk("rp_push1", {31'b0, push_en}, 32'h1);
    step();
    chk("rp_alt", {31'b0, push_en}, 32'h1);
    RST = 1;
    step(); RST = 0;
    chk("rp_mask", {28'b0, active_mask}, 32'hF);
    chk("rp_redir", {31'b0, redirect_valid}, 32'h0);
    chk("rp_stall", {31'b0, stall}, 32'h0);
    chk("rp_depth", env_stk.size(), 32'h0);
    step();
    chk("rp_redir2", {31'b0, redirect_valid}, 32'h0);

    // stack error handling
    stk_overflow = 1;
    step(); stk_overflow = 0;
`ifdef SIMT_STACK_CHECK_EN
    chk("er_err", {31'b0, err}, 32'h1);
    chk("er_stall", {31'b0, stall}, 32'h1);
    step(); step(); step();
    chk("er_err_hold", {31'b0, err}, 32'h1);
    chk("er_stall_hold", {31'b0, stall}, 32'h1);
    RST = 1;
    step(); RST = 0;
    chk("er_clr", {31'b0, err}, 32'h0);
    chk("er_stall_clr", {31'b0, stall}, 32'h0);
`else
    chk("er_ignored", {31'b0, err}, 32'h0);
    chk("er_nostall", {31'b0, stall}, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST           = ($urandom_range(0, 299) == 0);
      br_valid      = ($urandom_range(0, 9) < 3);
      br_taken_mask = 4'($urandom_range(0, 15));
      br_target     = $urandom & 32'h0000_FFFC;
      br_fallthru   = $urandom & 32'h0000_FFFC;
      br_reconv     = $urandom & 32'h0000_FFFC;
      pc_valid      = ($urandom_range(0, 9) < 6);
      if (m_sync != RECONV_NONE && $urandom_range(0, 1) == 1) pc = m_sync;
      else pc = $urandom & 32'h0000_FFFC;
      step();
    end
    RST = 0; br_valid = 0; pc_valid = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
